// File: rtl/bnn_popcount_accum_if.sv
// Handshake bundle between the popcount stage, the neuron accumulator
// and the next layer.
interface bnn_popcount_accum_if #(
    parameter int CWIDTH = 4,
    parameter int AWIDTH = 8
);
    logic              clr_i;
    logic [CWIDTH-1:0] cnt_i;
    logic              cnt_valid_i;
    logic              cnt_ready_o;
    logic [AWIDTH-1:0] thresh_i;
    logic [AWIDTH-1:0] sum_o;
    logic              act_o;
    logic              out_valid_o;
    logic              out_ready_i;

    modport master (
        output clr_i,
        output cnt_i,
        output cnt_valid_i,
        output thresh_i,
        output out_ready_i,
        input  cnt_ready_o,
        input  sum_o,
        input  act_o,
        input  out_valid_o
    );

    modport slave (
        input  clr_i,
        input  cnt_i,
        input  cnt_valid_i,
        input  thresh_i,
        input  out_ready_i,
        output cnt_ready_o,
        output sum_o,
        output act_o,
        output out_valid_o
    );
endinterface

// File: rtl/bnn_popcount_accum.sv
// Per-neuron popcount accumulator with threshold activation.
// Define BNN_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module bnn_popcount_accum #(
    parameter int CWIDTH = 4,
    parameter int NCHUNK = 4,
    parameter int AWIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    bnn_popcount_accum_if.slave  bus
);

    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    logic [1:0]        state;
    logic [AWIDTH-1:0] acc;
    logic [AWIDTH-1:0] thr;
    logic [IDXW-1:0]   idx;
    logic [AWIDTH-1:0] sum_q;
    logic              act_q;
    logic              valid_q;

    logic              beat;
    logic              last;
    logic              finish;
    logic [AWIDTH-1:0] cnt_ext;
    logic [AWIDTH-1:0] acc_add;
    logic [AWIDTH-1:0] fin;
    logic [AWIDTH-1:0] thr_eff;

    assign bus.cnt_ready_o = (state != S_DONE);
    assign bus.sum_o       = sum_q;
    assign bus.act_o       = act_q;
    assign bus.out_valid_o = valid_q;

    assign beat    = bus.cnt_valid_i && bus.cnt_ready_o;
    assign cnt_ext = AWIDTH'(bus.cnt_i);

`ifdef BNN_ACC_SAT_EN
    logic [AWIDTH:0] add_full;
    assign add_full = {1'b0, acc} + {1'b0, cnt_ext};
    assign acc_add  = add_full[AWIDTH] ? '1 : add_full[AWIDTH-1:0];
`else
    assign acc_add  = acc + cnt_ext;
`endif

    // First beat bypasses acc/thr so the result can land in the same edge
    always_comb begin
        fin     = acc_add;
        thr_eff = thr;
        last    = (idx == LAST_IDX);
        if (state == S_IDLE) begin
            fin     = cnt_ext;
            thr_eff = bus.thresh_i;
            last    = (NCHUNK == 1);
        end
    end

    assign finish = beat && last && !bus.clr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            thr   <= '0;
            idx   <= '0;
        end else if (bus.clr_i) begin
            state <= S_IDLE;
            acc   <= '0;
            idx   <= '0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (beat) begin
                        acc   <= cnt_ext;
                        thr   <= bus.thresh_i;
                        idx   <= IDXW'(1);
                        state <= last ? S_DONE : S_ACCUM;
                    end
                end
                (state == S_ACCUM): begin
                    if (beat) begin
                        acc <= acc_add;
                        idx <= idx + IDXW'(1);
                        if (last) state <= S_DONE;
                    end
                end
                (state == S_DONE): begin
                    if (bus.out_ready_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            act_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.clr_i) begin
            valid_q <= 1'b0;
        end else if (finish) begin
            sum_q   <= fin;
            act_q   <= (fin >= thr_eff);
            valid_q <= 1'b1;
        end else if (valid_q && bus.out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bnn_popcount_accum.sv
// Directed bench for bnn_popcount_accum: default build plus an
// AWIDTH=5 instance for the overflow behaviour.
module tb_bnn_popcount_accum;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    bnn_popcount_accum_if #(.CWIDTH(4), .AWIDTH(8)) b ();
    bnn_popcount_accum_if #(.CWIDTH(4), .AWIDTH(5)) b5 ();

    bnn_popcount_accum #(.CWIDTH(4), .NCHUNK(4), .AWIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    bnn_popcount_accum #(.CWIDTH(4), .NCHUNK(4), .AWIDTH(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] c);
        b.cnt_i       = c;
        b.cnt_valid_i = 1'b1;
        step();
        b.cnt_valid_i = 1'b0;
    endtask

    task automatic neuron(input logic [3:0] c0, input logic [3:0] c1,
                          input logic [3:0] c2, input logic [3:0] c3,
                          input logic [7:0] th);
        b.thresh_i = th;
        beat(c0);
        beat(c1);
        beat(c2);
        beat(c3);
    endtask

    initial begin
        rst_n          = 1'b0;
        b.clr_i        = 1'b0;
        b.cnt_i        = '0;
        b.cnt_valid_i  = 1'b0;
        b.thresh_i     = '0;
        b.out_ready_i  = 1'b1;
        b5.clr_i       = 1'b0;
        b5.cnt_i       = '0;
        b5.cnt_valid_i = 1'b0;
        b5.thresh_i    = '0;
        b5.out_ready_i = 1'b1;
        step();
        step();
        check("rst_valid", 32'(b.out_valid_o), 32'd0);
        check("rst_sum", 32'(b.sum_o), 32'd0);
        check("rst_act", 32'(b.act_o), 32'd0);
        check("rst_ready", 32'(b.cnt_ready_o), 32'd1);
        rst_n = 1'b1;
        step();

        // 8+9+10+11 = 38 >= 30
        b.thresh_i = 8'd30;
        beat(4'd8);
        beat(4'd9);
        beat(4'd10);
        check("lat_pre", 32'(b.out_valid_o), 32'd0);
        beat(4'd11);
        check("t1_valid", 32'(b.out_valid_o), 32'd1);
        check("t1_sum", 32'(b.sum_o), 32'd38);
        check("t1_act", 32'(b.act_o), 32'd1);
        check("t1_busy", 32'(b.cnt_ready_o), 32'd0);
        step();
        check("t1_drop", 32'(b.out_valid_o), 32'd0);
        check("t1_ready", 32'(b.cnt_ready_o), 32'd1);

        neuron(4'd1, 4'd1, 4'd1, 4'd1, 8'd4);
        check("eq_sum", 32'(b.sum_o), 32'd4);
        check("eq_act", 32'(b.act_o), 32'd1);
        step();
        neuron(4'd1, 4'd1, 4'd1, 4'd0, 8'd4);
        check("lt_sum", 32'(b.sum_o), 32'd3);
        check("lt_act", 32'(b.act_o), 32'd0);
        step();

        // threshold 13 captured on beat 1; later thresh_i=0 must not apply
        b.thresh_i = 8'd13;
        beat(4'd3);
        b.thresh_i = 8'd0;
        beat(4'd3);
        beat(4'd3);
        beat(4'd3);
        check("thr_sum", 32'(b.sum_o), 32'd12);
        check("thr_act", 32'(b.act_o), 32'd0);
        step();

        // backpressure with a pending input beat
        b.out_ready_i = 1'b0;
        neuron(4'd2, 4'd2, 4'd2, 4'd2, 8'd0);
        b.cnt_i       = 4'd7;
        b.cnt_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", 32'(b.cnt_ready_o), 32'd0);
            check("bp_valid", 32'(b.out_valid_o), 32'd1);
            check("bp_sum", 32'(b.sum_o), 32'd8);
            check("bp_act", 32'(b.act_o), 32'd1);
        end
        b.cnt_valid_i = 1'b0;
        b.out_ready_i = 1'b1;
        step();
        check("bp_rel_valid", 32'(b.out_valid_o), 32'd0);
        check("bp_rel_ready", 32'(b.cnt_ready_o), 32'd1);
        neuron(4'd1, 4'd1, 4'd1, 4'd1, 8'd5);
        check("bp_next_sum", 32'(b.sum_o), 32'd4);
        check("bp_next_act", 32'(b.act_o), 32'd0);
        step();

        // gaps between beats
        b.thresh_i = 8'd18;
        beat(4'd3);
        step();
        step();
        check("gap_hold", 32'(b.out_valid_o), 32'd0);
        beat(4'd4);
        beat(4'd5);
        beat(4'd6);
        check("gap_valid", 32'(b.out_valid_o), 32'd1);
        check("gap_sum", 32'(b.sum_o), 32'd18);
        check("gap_act", 32'(b.act_o), 32'd1);
        step();

        // abort after two beats, coincident beat discarded
        b.thresh_i = 8'd0;
        beat(4'd5);
        beat(4'd5);
        b.clr_i       = 1'b1;
        b.cnt_i       = 4'd9;
        b.cnt_valid_i = 1'b1;
        step();
        b.clr_i       = 1'b0;
        b.cnt_valid_i = 1'b0;
        check("clr_valid", 32'(b.out_valid_o), 32'd0);
        check("clr_ready", 32'(b.cnt_ready_o), 32'd1);
        neuron(4'd2, 4'd2, 4'd2, 4'd2, 8'd8);
        check("clr_sum", 32'(b.sum_o), 32'd8);
        check("clr_act", 32'(b.act_o), 32'd1);
        step();

        // asynchronous reset mid-neuron
        beat(4'd7);
        beat(4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(b.out_valid_o), 32'd0);
        check("arst_sum", 32'(b.sum_o), 32'd0);
        check("arst_act", 32'(b.act_o), 32'd0);
        check("arst_ready", 32'(b.cnt_ready_o), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        neuron(4'd1, 4'd2, 4'd3, 4'd4, 8'd11);
        check("arst_next_valid", 32'(b.out_valid_o), 32'd1);
        check("arst_next_sum", 32'(b.sum_o), 32'd10);
        check("arst_next_act", 32'(b.act_o), 32'd0);
        step();

        // 5-bit accumulator: 15*4
        b5.thresh_i    = 5'd31;
        b5.cnt_i       = 4'd15;
        b5.cnt_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        b5.cnt_valid_i = 1'b0;
        check("ovf_valid", 32'(b5.out_valid_o), 32'd1);
`ifdef BNN_ACC_SAT_EN
        check("ovf_sum", 32'(b5.sum_o), 32'd31);
        check("ovf_act", 32'(b5.act_o), 32'd1);
`else
        check("ovf_sum", 32'(b5.sum_o), 32'd28);
        check("ovf_act", 32'(b5.act_o), 32'd0);
`endif
        step();
        check("ovf_drop", 32'(b5.out_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
